reg_load_arbiter4: RTL and testbench
====================================

# reg_load_arbiter4

Round-robin load arbiter that shares one 8-bit negative-edge register with active-low load enable between four requesters. Each requester presents a byte and a request; the arbiter grants one at a time, drives the register's data input and `Enbar` for a programmable number of cycles, then acknowledges the winner. It sits directly in front of the shared register instance. The register's `Clkbar` port is tied to this block's `Clk`, so the register captures on the falling edge inside each load cycle.

## Interface
- `LOAD_CYCLES`, default 1: number of `Clk` cycles `Enbar` is held low per grant; legal range 1..15.
- `Clk` input 1: single clock; all arbiter state updates on the rising edge.
- `Resetbar` input 1: asynchronous, active-low reset.
- `req` input 4: request vector; bit i is requester i.
- `data` input 32: packed request data; requester i owns `data[8*i+7:8*i]`.
- `regIn` output 8: data to the shared register's `in`.
- `Enbar` output 1: active-low load enable to the shared register.
- `grant` output 4: one-hot, requester currently being served.
- `ack` output 4: one-hot, one-cycle completion pulse to the served requester.
- `busy` output 1: high while in LOAD or ACK.
- `owner` output 2: index of the requester whose data was last loaded.

## Operation
- States: IDLE, LOAD, ACK. All outputs are registered.
- Reset values: state IDLE, `Enbar`=1, `regIn`=8'h00, `grant`=4'b0000, `ack`=4'b0000, `busy`=0, `owner`=0, internal round-robin pointer `ptr`=0, cycle counter=0.
- IDLE with `req`==0: hold; `Enbar` stays 1.
- IDLE with `req`!=0:
  - Winner w is the first set bit searching ptr, ptr+1, ... modulo 4.
  - Latch `regIn`=data byte w, `grant`=1<<w, `Enbar`=0, `busy`=1, counter=LOAD_CYCLES-1.
  - Go to LOAD.
- LOAD:
  - If counter!=0, decrement and stay.
  - If counter==0, set `Enbar`=1, `ack`=1<<w, `owner`=w, `ptr`=(w+1) mod 4, and go to ACK.
- ACK: clear `ack`, `grant` and `busy`, then go to IDLE. Requests are not evaluated in ACK.
- `regIn` is latched at grant. Changes to `data` during LOAD are ignored.
- Deassertion of `req[w]` during LOAD is ignored; the load completes and is acknowledged.
- Requesters must drop `req` after seeing `ack`. A request still high in IDLE is treated as a new request and competes under the updated pointer.
- `grant` and `ack` are never multi-hot. `ack` is never high while `Enbar`=0.
- `regIn` holds its last value in IDLE; it is not cleared after a load.

## Timing
- Let `req` bit w be stable before rising edge k with the arbiter in IDLE.
- After edge k: `Enbar`=0, `grant`, `regIn` and `busy` are valid.
- The register captures `regIn` on each falling `Clk` edge while `Enbar`=0, i.e. LOAD_CYCLES captures, with half a cycle of setup.
- After edge k+LOAD_CYCLES: `Enbar`=1, `ack`[w]=1, `owner`=w.
- After edge k+LOAD_CYCLES+1: `ack`=0, `grant`=0, `busy`=0, state IDLE.
- The next grant appears at the earliest after edge k+LOAD_CYCLES+2. Per-transfer occupancy is LOAD_CYCLES+2 cycles.
- Reset asserted at any time, including mid-LOAD:
  - All outputs go to reset values immediately, without waiting for a clock edge; `Enbar` rises asynchronously.
  - No `ack` is issued for the aborted transfer.
  - The shared register keeps whatever it last captured.
- Reset deassertion is sampled at a rising edge. The first grant can occur at the first rising edge after release.

## Test plan
- Single request, LOAD_CYCLES=1:
  - Stimulus: `req`=4'b0100, byte 2 = 8'hA5.
  - Response: after edge k, `grant`=4'b0100, `Enbar`=0, `regIn`=8'hA5; register `out`=8'hA5 after the next falling edge.
  - Response: after edge k+1, `ack`=4'b0100, `owner`=2; after edge k+2, all idle.
- All four requesting, each holding `req` until its own `ack`, data 8'h11/8'h22/8'h33/8'h44:
  - Response: service order 0,1,2,3, acks every 3 cycles.
  - Response: register out sequence 11, 22, 33, 44.
- Fairness:
  - Stimulus: after serving requester 3 (`ptr`=0), requesters 1 and 3 assert together.
  - Response: 1 is served first, then 3.
  - Stimulus: requester 0 asserts immediately after requester 1 (`ptr`=2), together with 3.
  - Response: 3 is served before 0.
- LOAD_CYCLES=3:
  - Response: `Enbar` low for exactly 3 cycles.
  - Stimulus: `data` changed from 8'h0F to 8'hF0 during LOAD.
  - Response: `regIn` stays 8'h0F and register `out`=8'h0F.
- Reset mid-LOAD (LOAD_CYCLES=4):
  - Stimulus: pull `Resetbar` low in the second load cycle.
  - Response: `Enbar`=1, `grant`=0, `busy`=0 immediately; no `ack` pulse.
  - Stimulus: release reset with `req`=4'b1000.
  - Response: requester 3 is granted one edge after release, with `ptr` back at 0.
- Request dropped during LOAD:
  - Stimulus: `req[0]` deasserted in the LOAD cycle.
  - Response: `ack`[0] still pulses and `owner`=0.

Source files
------------

// File: rtl/reg_load_arbiter4_if.sv
// Bus between the four requesters and the shared-register load arbiter.
//   req    : request vector, bit i belongs to requester i
//   data   : packed request bytes, requester i owns data[8*i+7:8*i]
//   regIn  : byte presented to the shared register's data input
//   Enbar  : active-low load enable to the shared register
//   grant  : one-hot, requester currently being served
//   ack    : one-hot, single-cycle completion pulse
//   busy   : high while a transfer is in progress
//   owner  : index of the requester whose data was last loaded
// master = requester side, slave = arbiter side.
interface reg_load_arbiter4_if;
  logic [3:0]  req;
  logic [31:0] data;
  logic [7:0]  regIn;
  logic        Enbar;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  owner;

  modport master (output req, data,
                  input  regIn, Enbar, grant, ack, busy, owner);
  modport slave  (input  req, data,
                  output regIn, Enbar, grant, ack, busy, owner);
endinterface

// File: rtl/reg_load_arbiter4.sv
// Round-robin load arbiter in front of one shared 8-bit register whose
// Clkbar is tied to Clk. A winner's byte is latched onto regIn and Enbar is
// held low for LOAD_CYCLES cycles (the register captures on each falling
// edge), then the winner gets a one-cycle ack. Occupancy per transfer is
// LOAD_CYCLES+2 cycles.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Resetbar : asynchronous active-low reset
//   bus      : reg_load_arbiter4_if slave modport (req/data in,
//              regIn/Enbar/grant/ack/busy/owner out, all registered)
module reg_load_arbiter4 #(
  parameter int LOAD_CYCLES = 1
) (
  input logic              Clk,
  input logic              Resetbar,
  reg_load_arbiter4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] regin_q, regin_d;
  logic       enbar_q, enbar_d;
  logic       busy_q, busy_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] ack_q, ack_d;

  // First set request bit starting at the pointer, wrapping modulo 4.
  // Scanning from the farthest offset down lets the nearest one win last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge Clk or negedge Resetbar) begin
    if (!Resetbar) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      owner_q <= 2'd0;
      regin_q <= 8'h00;
      enbar_q <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 4'b0000;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      regin_q <= regin_d;
      enbar_q <= enbar_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    owner_d = owner_q;
    regin_d = regin_q;
    enbar_d = enbar_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    ack_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          win_d   = rr_pick(bus.req, ptr_q);
          // Data is sampled only here; later changes on the bus are ignored.
          regin_d = bus.data[{win_d, 3'b000} +: 8];
          grant_d = 4'b0001 << win_d;
          enbar_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          enbar_d = 1'b1;
          ack_d   = grant_q;
          owner_d = win_q;
          ptr_d   = win_q + 2'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.regIn = regin_q;
  assign bus.Enbar = enbar_q;
  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_reg_load_arbiter4.sv
module tb_reg_load_arbiter4;

  logic        clk = 1'b0;
  logic        resetbar;
  logic [3:0]  req;
  logic [31:0] data;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [2:0]       enbar_a, busy_a;
  logic [2:0][3:0]  grant_a, ack_a;
  logic [2:0][7:0]  regin_a, shreg_a;
  logic [2:0][1:0]  owner_a;

  // Three arbiters with LOAD_CYCLES 1, 3, 4 share the same requesters; each
  // drives its own stand-in for the shared negative-edge register.
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LC = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    reg_load_arbiter4_if bus ();
    logic [7:0] shreg = 8'h00;
    assign bus.req  = req;
    assign bus.data = data;
    reg_load_arbiter4 #(.LOAD_CYCLES(LC)) dut (
      .Clk      (clk),
      .Resetbar (resetbar),
      .bus      (bus)
    );
    always @(negedge clk) if (!bus.Enbar) shreg <= bus.regIn;
    assign enbar_a[g] = bus.Enbar;
    assign busy_a[g]  = bus.busy;
    assign grant_a[g] = bus.grant;
    assign ack_a[g]   = bus.ack;
    assign regin_a[g] = bus.regIn;
    assign owner_a[g] = bus.owner;
    assign shreg_a[g] = shreg;
  end

  // Reference model: a transfer is a timeline starting at the grant edge.
  int         m_start [3];
  logic [1:0] m_w     [3];
  logic [1:0] m_ptr   [3];
  logic [1:0] m_owner [3];
  logic [7:0] m_regv  [3];
  logic [7:0] m_reg   [3];

  int order_q[$];
  int ackcyc_q[$];
  int regout_q[$];

  function automatic int lc_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int j = (int'(p) + k) % 4;
      if (r[j]) return 2'(j);
    end
    return p;
  endfunction

  function automatic int idx_of(logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(string tag, int idx, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_start[i] = -1;
      m_w[i]     = 2'd0;
      m_ptr[i]   = 2'd0;
      m_owner[i] = 2'd0;
      m_regv[i]  = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int lc = lc_of(i);
      if (!resetbar) begin
        m_start[i] = -1;
        m_w[i]     = 2'd0;
        m_ptr[i]   = 2'd0;
        m_owner[i] = 2'd0;
        m_regv[i]  = 8'h00;
      end else if (m_start[i] < 0) begin
        if (req != 4'b0000) begin
          m_w[i]     = pick(req, m_ptr[i]);
          m_start[i] = cyc;
          m_regv[i]  = data[8*int'(m_w[i]) +: 8];
        end
      end else if (cyc - m_start[i] == lc + 1) begin
        m_start[i] = -1;
      end else if (cyc - m_start[i] == lc) begin
        m_owner[i] = m_w[i];
        m_ptr[i]   = m_w[i] + 2'd1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic       e_en, e_busy;
      logic [3:0] e_gr, e_ack;
      int         t;
      e_en = 1'b1; e_busy = 1'b0; e_gr = 4'b0000; e_ack = 4'b0000;
      if (m_start[i] >= 0) begin
        t = cyc - m_start[i];
        e_busy = 1'b1;
        e_gr   = 4'b0001 << m_w[i];
        if (t < lc_of(i)) e_en = 1'b0;
        else e_ack = 4'b0001 << m_w[i];
      end
      chk("Enbar", i, enbar_a[i], e_en);
      chk("grant", i, grant_a[i], e_gr);
      chk("ack",   i, ack_a[i],   e_ack);
      chk("busy",  i, busy_a[i],  e_busy);
      chk("regIn", i, regin_a[i], m_regv[i]);
      chk("owner", i, owner_a[i], m_owner[i]);
      chk("regout", i, shreg_a[i], m_reg[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (resetbar && m_start[i] >= 0 && (cyc - m_start[i]) < lc_of(i))
        m_reg[i] = m_regv[i];
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    req = 4'b0000;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    resetbar = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    resetbar = 1'b1;
  endtask

  // Requesters hold their bits until instance 0 acknowledges them.
  task automatic serve(int maxc);
    int n = 0;
    order_q.delete(); ackcyc_q.delete(); regout_q.delete();
    while (req != 4'b0000 && n < maxc) begin
      cycle();
      n++;
      if (ack_a[0] != 4'b0000) begin
        order_q.push_back(idx_of(ack_a[0]));
        ackcyc_q.push_back(cyc);
        regout_q.push_back(int'(shreg_a[0]));
      end
      req = req & ~ack_a[0];
    end
    chk("serve_done", 0, req, 4'b0000);
  endtask

  function automatic int q_at(int q[$], int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    int lowcnt;
    resetbar = 1'b1; req = 4'b0000; data = 32'h0;
    for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
    model_reset();
    #1 resetbar = 1'b0;
    #1;
    check_all();
    cycle(); cycle();
    resetbar = 1'b1;
    idle(2);

    // Single request, requester 2
    data = 32'h00A5_0000; req = 4'b0100;
    cycle();
    chk("single_grant", 0, grant_a[0], 4'b0100);
    chk("single_enbar", 0, enbar_a[0], 1'b0);
    chk("single_regIn", 0, regin_a[0], 8'hA5);
    chk("single_regout", 0, shreg_a[0], 8'hA5);
    cycle();
    chk("single_ack", 0, ack_a[0], 4'b0100);
    chk("single_owner", 0, owner_a[0], 2'd2);
    req = 4'b0000;
    cycle();
    chk("single_idle_busy", 0, busy_a[0], 1'b0);
    chk("single_idle_grant", 0, grant_a[0], 4'b0000);
    idle(6);

    // All four requesting from ptr=0
    do_reset();
    data = 32'h4433_2211; req = 4'b1111;
    serve(40);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", k, q_at(order_q, k), k);
      chk("rr_regout", k, q_at(regout_q, k), 8'h11 * (k + 1));
    end
    for (int k = 1; k < 4; k++)
      chk("rr_spacing", k, q_at(ackcyc_q, k) - q_at(ackcyc_q, k - 1), 3);
    idle(8);

    // Fairness: ptr=0, requesters 1 and 3
    req = 4'b1010;
    serve(40);
    chk("fair_a0", 0, q_at(order_q, 0), 1);
    chk("fair_a1", 1, q_at(order_q, 1), 3);
    idle(8);
    req = 4'b0010;
    serve(20);
    req = 4'b1001;
    serve(40);
    chk("fair_b0", 0, q_at(order_q, 0), 3);
    chk("fair_b1", 1, q_at(order_q, 1), 0);
    idle(8);

    // LOAD_CYCLES=3 hold time, data change during load, req dropped in load
    do_reset();
    data = 32'h0000_000F; req = 4'b0001;
    lowcnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (!enbar_a[1]) lowcnt++;
      if (c == 0) begin
        data = 32'h0000_00F0;
        req  = 4'b0000;
      end
      if (c == 1) begin
        chk("drop_ack", 0, ack_a[0], 4'b0001);
        chk("drop_owner", 0, owner_a[0], 2'd0);
      end
    end
    chk("lc3_low_cycles", 1, lowcnt, 3);
    chk("lc3_regIn", 1, regin_a[1], 8'h0F);
    chk("lc3_regout", 1, shreg_a[1], 8'h0F);

    // Reset in the second load cycle of the LOAD_CYCLES=4 instance
    do_reset();
    data = 32'h9900_0077; req = 4'b0100;
    cycle();
    cycle();
    resetbar = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("abort_enbar", 2, enbar_a[2], 1'b1);
    chk("abort_grant", 2, grant_a[2], 4'b0000);
    chk("abort_busy", 2, busy_a[2], 1'b0);
    req = 4'b1000;
    cycle();
    chk("abort_noack", 2, ack_a[2], 4'b0000);
    resetbar = 1'b1;
    cycle();
    chk("release_grant", 2, grant_a[2], 4'b1000);
    chk("release_regIn", 2, regin_a[2], 8'h99);
    idle(8);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      if (!resetbar) begin
        resetbar = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        resetbar = 1'b0;
        #1;
        model_reset();
        check_all();
      end
      req = req & ~ack_a[0];
      if ($urandom_range(0, 2) == 0) req = req | 4'($urandom);
      if ($urandom_range(0, 9) == 0) req = 4'b0000;
      data = $urandom;
      cycle();
    end
    resetbar = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
